mmio_bus_router: RTL and testbench
==================================

# mmio_bus_router

Parametrised memory-mapped I/O router between the single-cycle CPU data port and N peripheral slaves (data RAM, sprite controller, UART, future blocks). It replaces ad-hoc shared write-enable fan-out with registered one-hot slave selection, a ready handshake so slaves may insert wait states, and a per-access timeout. Unmapped or unresponsive accesses return a fixed error word and are logged in sticky status.

## Interface
Parameters:
- NUM_SLAVES, 4, number of slave ports (1..16)
- DATA_W, 32, data width
- ADDR_W, 32, CPU address width
- REGION_W, 10, log2 of the byte-address window per slave; the slave sees only the offset
- TIMEOUT, 16, cycles in ACCESS before error (>=2)
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high
- cpu_req_i  in  1  access request, held until cpu_ready_o
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  byte address
- cpu_wdata_i  in  DATA_W  store data
- cpu_rdata_o  out  DATA_W  load data, valid when cpu_ready_o
- cpu_ready_o  out  1  one-cycle completion pulse
- cpu_err_o  out  1  completion carries an error, qualified by cpu_ready_o
- s_sel_o  out  NUM_SLAVES  one-hot slave select
- s_we_o  out  1  shared write strobe, qualified by s_sel_o
- s_addr_o  out  REGION_W  shared offset
- s_wdata_o  out  DATA_W  shared write data
- s_rdata_i  in  NUM_SLAVES*DATA_W  packed read data, slave k at [k*DATA_W +: DATA_W]
- s_ready_i  in  NUM_SLAVES  per-slave ready
- err_clr_i  in  1  clears err_o and err_count_o
- err_o  out  1  sticky error flag
- err_addr_o  out  ADDR_W  address of most recent errored access
- err_count_o  out  8  saturating error counter

## Operation
- Decode: IDX_W = max(1, $clog2(NUM_SLAVES)); idx = cpu_addr_i[REGION_W +: IDX_W]. Mapped iff idx < NUM_SLAVES and cpu_addr_i[ADDR_W-1 : REGION_W+IDX_W] == 0.
- FSM states IDLE, ACCESS, RESP.
- IDLE: on cpu_req_i, register addr offset, wdata, we. Mapped -> s_sel_o = 1<<idx, go ACCESS, clear timer. Unmapped -> no select, go RESP with error.
- ACCESS: s_sel_o, s_we_o, s_addr_o, s_wdata_o held stable. s_ready_i[idx]=1 -> capture s_rdata_i slice into cpu_rdata_o, drop select, go RESP, no error. Timer reaches TIMEOUT-1 without ready -> drop select, go RESP with error. Ready and timeout same cycle: ready wins, no error.
- RESP: cpu_ready_o=1 for exactly one cycle; cpu_err_o as recorded; cpu_rdata_o = ERR_DATA on error (loads and stores), captured data otherwise, 0 for successful stores. Next state IDLE; cpu_req_i ignored in RESP.
- Error logging on entry to RESP with error: err_o<=1, err_addr_o<=full CPU address, err_count_o increments, saturating at 255. err_clr_i clears flag and count; err_clr_i and new error same cycle: error wins, count becomes 1.
- Ready from non-selected slaves ignored.
- Reset (any state, including mid-ACCESS): state IDLE, all outputs 0, timer 0; pending access dropped, no ready pulse.

## Timing
- Request sampled at edge T (IDLE): s_sel_o high from T+1.
- Ready-to-completion: s_ready_i[idx] sampled high at edge T+k (k>=1), cpu_ready_o high during T+k+1 only. Minimum load/store latency 2 cycles (slave ready combinationally while selected).
- Unmapped: cpu_ready_o with cpu_err_o high during T+1.
- Timeout: select high T+1..T+TIMEOUT; error completion during T+TIMEOUT+1.
- Back-to-back: new request earliest sampled at edge after RESP; throughput one access per 3 cycles.
- Slave write occurs on a cycle where s_sel_o[k] & s_we_o & s_ready_i[k].

## Structure
- Package mmio_pkg: state enum (IDLE, ACCESS, RESP), default ERR_DATA, idx-width function.
- Sub-module mmio_addr_decode: combinational address -> {mapped, idx, one-hot}; parametrised on NUM_SLAVES, ADDR_W, REGION_W. FSM, timer, data capture, error log in the router.

## Test plan
- Load from slave 2 offset 0x004 (addr 0x0000_0804), slave ready immediately, rdata 0x1234_5678 -> s_sel_o=4'b0100, s_addr_o=0x004, cpu_ready_o 2 cycles after request, cpu_rdata_o=0x1234_5678, cpu_err_o=0.
- Store 0xCAFE_0001 to slave 1 with ready delayed 3 cycles -> select/we/data stable 4 cycles, completion on 5th, err_o stays 0.
- Load from 0x0001_0000 (upper bits set) -> no select, ready+err next cycle, rdata 0xDEAD_BEEF, err_addr_o=0x0001_0000, err_count_o=1.
- Slave 0 never ready, TIMEOUT=16 -> select 16 cycles, error completion on 17th; repeat to 256 errors -> count holds 255; err_clr_i with concurrent error -> count 1.
- Ready arriving exactly on timeout cycle -> normal completion, no error; ready pulse from non-selected slave ignored.
- Reset asserted mid-ACCESS -> next cycle s_sel_o=0, state IDLE, no cpu_ready_o; subsequent access completes normally.

Source files
------------

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared state type, default error word and index-width helper
// for the MMIO bus router and its address decoder.
package mmio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    // Bits needed to index n slaves, never less than one.
    function automatic int idx_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/mmio_bus_router_if.sv
// Bus interfaces for the MMIO router: mmio_cpu_if carries the CPU data port
// (master = CPU, slave = router); mmio_slv_if carries the shared slave bus
// (master = router, slave = peripherals).
interface mmio_cpu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_ready_o;
    logic              cpu_err_o;

    modport master (
        output cpu_req_i,
        output cpu_we_i,
        output cpu_addr_i,
        output cpu_wdata_i,
        input  cpu_rdata_o,
        input  cpu_ready_o,
        input  cpu_err_o
    );

    modport slave (
        input  cpu_req_i,
        input  cpu_we_i,
        input  cpu_addr_i,
        input  cpu_wdata_i,
        output cpu_rdata_o,
        output cpu_ready_o,
        output cpu_err_o
    );
endinterface

interface mmio_slv_if #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32,
    parameter int REGION_W   = 10
);
    logic [NUM_SLAVES-1:0]        s_sel_o;
    logic                         s_we_o;
    logic [REGION_W-1:0]          s_addr_o;
    logic [DATA_W-1:0]            s_wdata_o;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i;
    logic [NUM_SLAVES-1:0]        s_ready_i;

    modport master (
        output s_sel_o,
        output s_we_o,
        output s_addr_o,
        output s_wdata_o,
        input  s_rdata_i,
        input  s_ready_i
    );

    modport slave (
        input  s_sel_o,
        input  s_we_o,
        input  s_addr_o,
        input  s_wdata_o,
        output s_rdata_i,
        output s_ready_i
    );
endinterface

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational CPU address -> {mapped, idx, onehot}.
// Ports: addr in; mapped, idx (slave index), onehot (slave select) out.
module mmio_addr_decode
    import mmio_pkg::*;
#(
    parameter  int NUM_SLAVES = 4,
    parameter  int ADDR_W     = 32,
    parameter  int REGION_W   = 10,
    localparam int IDX_W      = idx_width(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic                  mapped,
    output logic [IDX_W-1:0]      idx,
    output logic [NUM_SLAVES-1:0] onehot
);

    localparam int HI_LSB = REGION_W + IDX_W;

    logic upper_zero;
    logic in_range;
    logic unused_low;

    assign idx        = addr[REGION_W +: IDX_W];
    // Anything above the index field must be zero for a valid window.
    assign upper_zero = (addr >> HI_LSB) == '0;
    assign in_range   = int'(idx) < NUM_SLAVES;
    assign mapped     = upper_zero & in_range;
    assign onehot     = mapped ? (NUM_SLAVES'(1) << idx) : '0;

    // Offset bits are handled by the router, not the decoder.
    assign unused_low = ^addr[REGION_W-1:0];

endmodule

// File: rtl/mmio_bus_router.sv
// mmio_bus_router: routes CPU MMIO accesses to one of NUM_SLAVES slaves with
// registered one-hot select, ready wait states, timeout and sticky error log.
// Ports: clk, reset; cpu (CPU data port); slv (shared slave bus);
// err_clr_i in; err_o, err_addr_o, err_count_o sticky error status out.
module mmio_bus_router
    import mmio_pkg::*;
#(
    parameter int              NUM_SLAVES = 4,
    parameter int              DATA_W     = 32,
    parameter int              ADDR_W     = 32,
    parameter int              REGION_W   = 10,
    parameter int              TIMEOUT    = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    mmio_cpu_if.slave         cpu,
    mmio_slv_if.master        slv,
    input  logic              err_clr_i,
    output logic              err_o,
    output logic [ADDR_W-1:0] err_addr_o,
    output logic [7:0]        err_count_o
);

    localparam int IDX_W = idx_width(NUM_SLAVES);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t state_q;
    state_t state_d;

    logic                  dec_mapped;
    logic [IDX_W-1:0]      dec_idx;
    logic [NUM_SLAVES-1:0] dec_onehot;

    logic [NUM_SLAVES-1:0] sel_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  we_q;
    logic [REGION_W-1:0]   off_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [ADDR_W-1:0]     addr_q;
    logic                  err_q;
    logic [TMR_W-1:0]      tmr_q;

    logic                  accept;
    logic                  done_ok;
    logic                  done_err;
    logic                  hit;
    logic                  expire;
    logic                  log_err;
    logic [ADDR_W-1:0]     log_addr;
    logic [DATA_W-1:0]     slv_rdata;
    logic                  resp;

    mmio_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .REGION_W   (REGION_W)
    ) u_dec (
        .addr   (cpu.cpu_addr_i),
        .mapped (dec_mapped),
        .idx    (dec_idx),
        .onehot (dec_onehot)
    );

    // Masking with the live select discards ready from other slaves.
    assign hit       = |(slv.s_ready_i & sel_q);
    assign expire    = tmr_q == TMR_LAST;
    assign slv_rdata = slv.s_rdata_i[int'(idx_q)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        done_ok  = 1'b0;
        done_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu.cpu_req_i) begin
                    accept  = 1'b1;
                    state_d = dec_mapped ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                // Ready is checked first so it wins on the timeout cycle.
                if (hit) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else if (expire) begin
                    done_err = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            tmr_q   <= '0;
        end else begin
            if (accept) begin
                sel_q   <= dec_onehot;
                idx_q   <= dec_idx;
                we_q    <= cpu.cpu_we_i;
                off_q   <= cpu.cpu_addr_i[REGION_W-1:0];
                wdata_q <= cpu.cpu_wdata_i;
                addr_q  <= cpu.cpu_addr_i;
                tmr_q   <= '0;
                err_q   <= ~dec_mapped;
                rdata_q <= dec_mapped ? '0 : ERR_DATA;
            end
            if (state_q == ACCESS) begin
                tmr_q <= tmr_q + 1'b1;
                if (done_ok) begin
                    sel_q   <= '0;
                    err_q   <= 1'b0;
                    rdata_q <= we_q ? '0 : slv_rdata;
                end else if (done_err) begin
                    sel_q   <= '0;
                    err_q   <= 1'b1;
                    rdata_q <= ERR_DATA;
                end
            end
        end
    end

    // Errors are logged on the edge that enters RESP with an error.
    assign log_err  = (accept & ~dec_mapped) | done_err;
    assign log_addr = accept ? cpu.cpu_addr_i : addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_o       <= 1'b0;
            err_addr_o  <= '0;
            err_count_o <= '0;
        end else if (log_err) begin
            err_o      <= 1'b1;
            err_addr_o <= log_addr;
            if (err_clr_i) begin
                err_count_o <= 8'd1;
            end else if (err_count_o != 8'hFF) begin
                err_count_o <= err_count_o + 8'd1;
            end
        end else if (err_clr_i) begin
            err_o       <= 1'b0;
            err_count_o <= '0;
        end
    end

    assign resp            = state_q == RESP;
    assign cpu.cpu_ready_o = resp;
    assign cpu.cpu_err_o   = resp & err_q;
    assign cpu.cpu_rdata_o = resp ? rdata_q : '0;

    assign slv.s_sel_o   = sel_q;
    assign slv.s_we_o    = we_q;
    assign slv.s_addr_o  = off_q;
    assign slv.s_wdata_o = wdata_q;

endmodule

// File: tb/tb_mmio_bus_router.sv
// tb_mmio_bus_router: directed vectors for mmio_bus_router
// (4 slaves, 1 KiB windows, TIMEOUT 16).
module tb_mmio_bus_router;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          err_clr;
    logic          err_flag;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_count;

    int n_vec = 0;
    int n_bad = 0;

    mmio_cpu_if #(.DATA_W(DW), .ADDR_W(AW)) cpu_bus ();
    mmio_slv_if #(.NUM_SLAVES(NS), .DATA_W(DW), .REGION_W(RW)) slv_bus ();

    mmio_bus_router #(
        .NUM_SLAVES (NS),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .REGION_W   (RW),
        .TIMEOUT    (TO),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu         (cpu_bus),
        .slv         (slv_bus),
        .err_clr_i   (err_clr),
        .err_o       (err_flag),
        .err_addr_o  (err_addr),
        .err_count_o (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation ran too long");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset               = 1'b1;
        err_clr             = 1'b0;
        cpu_bus.cpu_req_i   = 1'b0;
        cpu_bus.cpu_we_i    = 1'b0;
        cpu_bus.cpu_addr_i  = '0;
        cpu_bus.cpu_wdata_i = '0;
        slv_bus.s_rdata_i   = '0;
        slv_bus.s_ready_i   = '0;
        tick();
        tick();
        check("rst_sel", slv_bus.s_sel_o, 0);
        check("rst_rdy", cpu_bus.cpu_ready_o, 0);
        check("rst_err", err_flag, 0);
        check("rst_cnt", err_count, 0);
        reset = 1'b0;
        tick();

        // Load slave 2 offset 4, ready immediately.
        slv_bus.s_rdata_i[2*DW +: DW] = 32'h1234_5678;
        slv_bus.s_ready_i  = 4'b0100;
        cpu_bus.cpu_addr_i = 32'h0000_0804;
        cpu_bus.cpu_we_i   = 1'b0;
        cpu_bus.cpu_req_i  = 1'b1;
        tick();
        check("t1_sel", slv_bus.s_sel_o, 4'b0100);
        check("t1_off", slv_bus.s_addr_o, 10'h004);
        check("t1_rdy0", cpu_bus.cpu_ready_o, 0);
        tick();
        check("t1_rdy", cpu_bus.cpu_ready_o, 1);
        check("t1_data", cpu_bus.cpu_rdata_o, 32'h1234_5678);
        check("t1_cerr", cpu_bus.cpu_err_o, 0);
        check("t1_sel0", slv_bus.s_sel_o, 0);
        cpu_bus.cpu_req_i = 1'b0;
        slv_bus.s_ready_i = '0;
        tick();
        check("t1_idle", cpu_bus.cpu_ready_o, 0);

        // Store to slave 1 with three wait states.
        cpu_bus.cpu_addr_i  = 32'h0000_0410;
        cpu_bus.cpu_we_i    = 1'b1;
        cpu_bus.cpu_wdata_i = 32'hCAFE_0001;
        cpu_bus.cpu_req_i   = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_sel", slv_bus.s_sel_o, 4'b0010);
            check("t2_we", slv_bus.s_we_o, 1);
            check("t2_wd", slv_bus.s_wdata_o, 32'hCAFE_0001);
            check("t2_off", slv_bus.s_addr_o, 10'h010);
            check("t2_rdy0", cpu_bus.cpu_ready_o, 0);
            if (i == 3) slv_bus.s_ready_i = 4'b0010;
            tick();
        end
        check("t2_rdy", cpu_bus.cpu_ready_o, 1);
        check("t2_cerr", cpu_bus.cpu_err_o, 0);
        check("t2_data", cpu_bus.cpu_rdata_o, 0);
        check("t2_sel0", slv_bus.s_sel_o, 0);
        check("t2_errf", err_flag, 0);
        cpu_bus.cpu_req_i = 1'b0;
        cpu_bus.cpu_we_i  = 1'b0;
        slv_bus.s_ready_i = '0;
        tick();

        // Unmapped load: upper address bits set.
        cpu_bus.cpu_addr_i = 32'h0001_0000;
        cpu_bus.cpu_req_i  = 1'b1;
        tick();
        check("t3_sel", slv_bus.s_sel_o, 0);
        check("t3_rdy", cpu_bus.cpu_ready_o, 1);
        check("t3_cerr", cpu_bus.cpu_err_o, 1);
        check("t3_data", cpu_bus.cpu_rdata_o, 32'hDEAD_BEEF);
        check("t3_errf", err_flag, 1);
        check("t3_eadr", err_addr, 32'h0001_0000);
        check("t3_cnt", err_count, 1);
        cpu_bus.cpu_req_i = 1'b0;
        tick();

        // Slave 0 never ready: timeout.
        cpu_bus.cpu_addr_i = 32'h0000_0008;
        cpu_bus.cpu_req_i  = 1'b1;
        tick();
        n = 0;
        while (slv_bus.s_sel_o == 4'b0001 && n < 40) begin
            n++;
            tick();
        end
        check("t4_selcyc", n, TO);
        check("t4_rdy", cpu_bus.cpu_ready_o, 1);
        check("t4_cerr", cpu_bus.cpu_err_o, 1);
        check("t4_data", cpu_bus.cpu_rdata_o, 32'hDEAD_BEEF);
        check("t4_eadr", err_addr, 32'h0000_0008);
        check("t4_cnt", err_count, 2);
        cpu_bus.cpu_req_i = 1'b0;
        tick();

        // Push to 256 total errors; counter saturates.
        cpu_bus.cpu_addr_i = 32'h0001_0000;
        for (int i = 0; i < 254; i++) begin
            cpu_bus.cpu_req_i = 1'b1;
            tick();
            cpu_bus.cpu_req_i = 1'b0;
            tick();
        end
        check("t5_sat", err_count, 255);
        check("t5_errf", err_flag, 1);

        // Clear together with a new error: error wins, count 1.
        cpu_bus.cpu_addr_i = 32'h0002_0000;
        cpu_bus.cpu_req_i  = 1'b1;
        err_clr            = 1'b1;
        tick();
        err_clr           = 1'b0;
        cpu_bus.cpu_req_i = 1'b0;
        check("t5_clrcnt", err_count, 1);
        check("t5_clrf", err_flag, 1);
        check("t5_clradr", err_addr, 32'h0002_0000);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t5_clr0", err_count, 0);
        check("t5_clrf0", err_flag, 0);

        // Ready on the final timeout cycle; stray ready from slave 0.
        slv_bus.s_rdata_i[3*DW +: DW] = 32'h0BAD_F00D;
        slv_bus.s_rdata_i[0*DW +: DW] = 32'h1111_1111;
        cpu_bus.cpu_addr_i = 32'h0000_0FFC;
        cpu_bus.cpu_req_i  = 1'b1;
        tick();
        check("t6_off", slv_bus.s_addr_o, 10'h3FC);
        for (int i = 0; i < TO; i++) begin
            check("t6_sel", slv_bus.s_sel_o, 4'b1000);
            check("t6_rdy0", cpu_bus.cpu_ready_o, 0);
            if (i == TO - 1) slv_bus.s_ready_i = 4'b1000;
            else if (i % 4 == 1) slv_bus.s_ready_i = 4'b0001;
            else slv_bus.s_ready_i = 4'b0000;
            tick();
        end
        check("t6_rdy", cpu_bus.cpu_ready_o, 1);
        check("t6_cerr", cpu_bus.cpu_err_o, 0);
        check("t6_data", cpu_bus.cpu_rdata_o, 32'h0BAD_F00D);
        check("t6_cnt", err_count, 0);
        cpu_bus.cpu_req_i = 1'b0;
        slv_bus.s_ready_i = '0;
        tick();

        // Reset in the middle of an access.
        cpu_bus.cpu_addr_i = 32'h0000_0400;
        cpu_bus.cpu_req_i  = 1'b1;
        tick();
        tick();
        tick();
        check("t7_sel", slv_bus.s_sel_o, 4'b0010);
        reset             = 1'b1;
        cpu_bus.cpu_req_i = 1'b0;
        tick();
        check("t7_rsel", slv_bus.s_sel_o, 0);
        check("t7_rrdy", cpu_bus.cpu_ready_o, 0);
        reset = 1'b0;
        tick();
        check("t7_idle", cpu_bus.cpu_ready_o, 0);
        check("t7_isel", slv_bus.s_sel_o, 0);
        slv_bus.s_rdata_i[1*DW +: DW] = 32'h55AA_33CC;
        slv_bus.s_ready_i  = 4'b0010;
        cpu_bus.cpu_addr_i = 32'h0000_0408;
        cpu_bus.cpu_req_i  = 1'b1;
        tick();
        check("t7_sel2", slv_bus.s_sel_o, 4'b0010);
        tick();
        check("t7_rdy", cpu_bus.cpu_ready_o, 1);
        check("t7_data", cpu_bus.cpu_rdata_o, 32'h55AA_33CC);
        check("t7_cerr", cpu_bus.cpu_err_o, 0);
        cpu_bus.cpu_req_i = 1'b0;
        slv_bus.s_ready_i = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
